// File: rtl/cache_mem_if.sv
// Cache-to-memory request/return bundle: read request with beat return channel, plus write request.
interface cache_mem_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [1:0]   ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output wr_req, wr_type, wr_addr, wr_data,
    input  wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  wr_req, wr_type, wr_addr, wr_data,
    output wr_rdy
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Backing-memory responder for a cache: word/line reads returned as beats after RD_LATENCY idle cycles,
// no backpressure on returns; writes commit on acceptance, then wr_rdy drops for WR_LATENCY cycles.
module cache_mem_responder #(
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WR_LATENCY = 3
) (
  input logic        clk,
  input logic        resetn,
  cache_mem_if.slave bus
);
  localparam int unsigned DEPTH       = 1 << MEM_AW;
  localparam logic [3:0]  RD_CNT_INIT = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;
  localparam logic [3:0]  WR_CNT_INIT = 4'(WR_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic       {W_IDLE, W_BUSY} wr_state_t;

  logic [31:0] mem [DEPTH];

  rd_state_t         rd_state, rd_state_nxt;
  wr_state_t         wr_state, wr_state_nxt;
  logic [3:0]        rd_cnt, rd_cnt_nxt;
  logic [3:0]        wr_cnt, wr_cnt_nxt;
  logic [1:0]        beat, beat_nxt;
  logic              rd_line, rd_line_nxt;
  logic [MEM_AW-1:0] rd_idx, rd_idx_nxt;
  logic [MEM_AW-1:0] beat_idx;
  logic              beat_last;
  logic              wr_acc;
  logic              wr_line;
  logic [MEM_AW-1:0] wr_idx;
  logic              unused_addr_bits;

  // Upper address bits alias and byte offsets are irrelevant for word storage.
  assign unused_addr_bits = ^{bus.rd_addr, bus.wr_addr};

  assign beat_idx  = rd_line ? {rd_idx[MEM_AW-1:2], beat} : rd_idx;
  assign beat_last = !rd_line || (beat == 2'd3);

  assign wr_line = (bus.wr_type == 3'b100);
  assign wr_idx  = bus.wr_addr[MEM_AW+1:2];
  assign wr_acc  = resetn && bus.wr_req && (wr_state == W_IDLE);

  always_comb begin
    rd_state_nxt  = rd_state;
    rd_cnt_nxt    = rd_cnt;
    beat_nxt      = beat;
    rd_line_nxt   = rd_line;
    rd_idx_nxt    = rd_idx;
    bus.rd_rdy    = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 2'b00;
    bus.ret_data  = '0;
    unique case (rd_state)
      R_IDLE: begin
        bus.rd_rdy = 1'b1;
        if (bus.rd_req) begin
          rd_line_nxt  = (bus.rd_type == 3'b100);
          rd_idx_nxt   = bus.rd_addr[MEM_AW+1:2];
          beat_nxt     = 2'd0;
          rd_cnt_nxt   = RD_CNT_INIT;
          rd_state_nxt = (RD_LATENCY > 0) ? R_WAIT : R_DATA;
        end
      end
      R_WAIT: begin
        if (rd_cnt == 4'd0) rd_state_nxt = R_DATA;
        else                rd_cnt_nxt   = rd_cnt - 4'd1;
      end
      R_DATA: begin
        // Array is read live so a write committed earlier in the transfer is visible.
        bus.ret_valid = 1'b1;
        bus.ret_last  = {1'b0, beat_last};
        bus.ret_data  = mem[beat_idx];
        beat_nxt      = beat + 2'd1;
        if (beat_last) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_cnt_nxt   = wr_cnt;
    bus.wr_rdy   = 1'b0;
    case (wr_state)
      W_IDLE: begin
        bus.wr_rdy = 1'b1;
        if (bus.wr_req) begin
          wr_state_nxt = W_BUSY;
          wr_cnt_nxt   = WR_CNT_INIT;
        end
      end
      W_BUSY: begin
        if (wr_cnt == 4'd0) wr_state_nxt = W_IDLE;
        else                wr_cnt_nxt   = wr_cnt - 4'd1;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 4'd0;
      beat     <= 2'd0;
      rd_line  <= 1'b0;
      rd_idx   <= '0;
      wr_state <= W_IDLE;
      wr_cnt   <= 4'd0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_cnt   <= rd_cnt_nxt;
      beat     <= beat_nxt;
      rd_line  <= rd_line_nxt;
      rd_idx   <= rd_idx_nxt;
      wr_state <= wr_state_nxt;
      wr_cnt   <= wr_cnt_nxt;
    end
  end

  // Storage is deliberately not reset; committed data survives a reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (wr_line) begin
        for (int k = 0; k < 4; k++) begin
          mem[{wr_idx[MEM_AW-1:2], 2'(k)}] <= bus.wr_data[32*k +: 32];
        end
      end else begin
        mem[wr_idx] <= bus.wr_data[31:0];
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed plus randomized bench for cache_mem_responder against a word-array reference model.
module tb_cache_mem_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int RL    = 2;
  localparam int WL    = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cache_mem_if bus ();

  cache_mem_responder #(.MEM_AW(AW), .RD_LATENCY(RL), .WR_LATENCY(WL)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  logic [31:0] mdl [DEPTH];
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [2:0] t, input logic [127:0] d);
    int i;
    i = widx(a);
    if (t == 3'b100) begin
      for (int k = 0; k < 4; k++) mdl[(i & ~3) + k] = d[32*k +: 32];
    end else begin
      mdl[i] = d[31:0];
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [2:0] t, input logic [127:0] d);
    chk("wr_rdy_pre", bus.wr_rdy, 1);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_type = t; bus.wr_data = d;
    tick();
    mdl_write(a, t, d);
    bus.wr_req = 1'b0;
    for (int c = 0; c < WL; c++) begin
      chk("wr_rdy_busy", bus.wr_rdy, 0);
      tick();
    end
    chk("wr_rdy_done", bus.wr_rdy, 1);
  endtask

  // inj = cycle (0 = same edge as read acceptance) at which a write is presented; -1 = none.
  task automatic do_read(input logic [31:0] a, input logic [2:0] t, input int inj,
                         input logic [31:0] wa, input logic [2:0] wt, input logic [127:0] wd,
                         input bit noise);
    int i, n, base, total, bt;
    i     = widx(a);
    n     = (t == 3'b100) ? 4 : 1;
    base  = (t == 3'b100) ? (i & ~3) : i;
    total = RL + n;
    chk("rd_rdy_pre", bus.rd_rdy, 1);
    chk("ret_valid_pre", bus.ret_valid, 0);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_type = t;
    if (inj == 0) begin
      chk("wr_rdy_inj", bus.wr_rdy, 1);
      bus.wr_req = 1'b1; bus.wr_addr = wa; bus.wr_type = wt; bus.wr_data = wd;
    end
    tick();
    if (inj == 0) begin
      mdl_write(wa, wt, wd);
      bus.wr_req = 1'b0;
    end
    bus.rd_req = noise; bus.rd_addr = $urandom; bus.rd_type = 3'(~t);
    for (int c = 1; c <= total; c++) begin
      chk("rd_rdy_busy", bus.rd_rdy, 0);
      if (c <= RL) begin
        chk("ret_valid_wait", bus.ret_valid, 0);
        chk("ret_data_wait", bus.ret_data, 0);
      end else begin
        bt = c - RL - 1;
        chk("ret_valid_beat", bus.ret_valid, 1);
        chk("ret_last_beat", bus.ret_last, {1'b0, (bt == n - 1)});
        chk("ret_data_beat", bus.ret_data, mdl[base + bt]);
      end
      if (inj == c) begin
        chk("wr_rdy_inj", bus.wr_rdy, 1);
        bus.wr_req = 1'b1; bus.wr_addr = wa; bus.wr_type = wt; bus.wr_data = wd;
      end
      tick();
      if (inj == c) begin
        mdl_write(wa, wt, wd);
        bus.wr_req = 1'b0;
      end
    end
    bus.rd_req = 1'b0;
    chk("rd_rdy_post", bus.rd_rdy, 1);
    chk("ret_valid_post", bus.ret_valid, 0);
    chk("ret_last_post", bus.ret_last, 0);
    chk("ret_data_post", bus.ret_data, 0);
  endtask

  initial begin
    logic [31:0]  a, wa;
    logic [2:0]   t, wt;
    logic [127:0] d1, d2;
    int           inj, base;

    bus.rd_req = 1'b0; bus.rd_type = 3'd0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_type = 3'd0; bus.wr_addr = '0; bus.wr_data = '0;
    resetn = 1'b0;
    tick(); tick();
    chk("reset_rd_rdy", bus.rd_rdy, 1);
    chk("reset_wr_rdy", bus.wr_rdy, 1);
    chk("reset_ret_valid", bus.ret_valid, 0);
    chk("reset_ret_last", bus.ret_last, 0);
    chk("reset_ret_data", bus.ret_data, 0);
    resetn = 1'b1;
    tick();

    // Give every word a known value so later reads are fully checkable.
    for (int j = 0; j < DEPTH / 4; j++) do_write(32'(j * 16), 3'b100, rnd128());

    do_write(32'h1000, 3'b100, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
    do_read(32'h1008, 3'b100, -1, '0, '0, '0, 1'b0);
    do_read(32'h1004, 3'b010, -1, '0, '0, '0, 1'b0);

    // Held write request must wait out the busy window.
    d1 = rnd128(); d2 = rnd128();
    chk("hold_wr_rdy_pre", bus.wr_rdy, 1);
    bus.wr_req = 1'b1; bus.wr_addr = 32'h600; bus.wr_type = 3'b100; bus.wr_data = d1;
    tick();
    mdl_write(32'h600, 3'b100, d1);
    bus.wr_addr = 32'h640; bus.wr_data = d2;
    for (int c = 0; c < WL; c++) begin
      chk("hold_wr_rdy_busy", bus.wr_rdy, 0);
      tick();
    end
    chk("hold_wr_rdy_free", bus.wr_rdy, 1);
    tick();
    mdl_write(32'h640, 3'b100, d2);
    bus.wr_req = 1'b0;
    chk("hold_wr_rdy_again", bus.wr_rdy, 0);
    repeat (WL) tick();
    do_read(32'h640, 3'b100, -1, '0, '0, '0, 1'b0);
    do_read(32'h600, 3'b100, -1, '0, '0, '0, 1'b0);

    do_read(32'h2000, 3'b100, 0, 32'h2000, 3'b100,
            {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 1'b0);
    repeat (WL) tick();
    do_read(32'h2040, 3'b100, RL + 1, 32'h2044, 3'b100, rnd128(), 1'b1);
    repeat (WL) tick();

    do_write(32'h00000010, 3'b000, rnd128());
    do_read(32'h00001010, 3'b000, -1, '0, '0, '0, 1'b0);

    // Reset during the second beat of a line read, with a write still busy.
    base = widx(32'h300);
    chk("rst_rd_rdy_pre", bus.rd_rdy, 1);
    bus.rd_req = 1'b1; bus.rd_addr = 32'h300; bus.rd_type = 3'b100;
    tick();
    bus.rd_req = 1'b0;
    repeat (RL) tick();
    chk("rst_beat0_valid", bus.ret_valid, 1);
    chk("rst_beat0_data", bus.ret_data, mdl[base]);
    d1 = rnd128();
    chk("rst_wr_rdy_pre", bus.wr_rdy, 1);
    bus.wr_req = 1'b1; bus.wr_addr = 32'h500; bus.wr_type = 3'b000; bus.wr_data = d1;
    tick();
    mdl_write(32'h500, 3'b000, d1);
    chk("rst_beat1_valid", bus.ret_valid, 1);
    chk("rst_beat1_data", bus.ret_data, mdl[base + 1]);
    chk("rst_wr_busy", bus.wr_rdy, 0);
    resetn = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 32'h300; bus.rd_type = 3'b100;
    bus.wr_req = 1'b1; bus.wr_addr = 32'h300; bus.wr_type = 3'b100; bus.wr_data = ~rnd128();
    tick();
    chk("rst_ret_valid", bus.ret_valid, 0);
    chk("rst_ret_last", bus.ret_last, 0);
    chk("rst_ret_data", bus.ret_data, 0);
    chk("rst_rd_rdy", bus.rd_rdy, 1);
    chk("rst_wr_rdy", bus.wr_rdy, 1);
    resetn = 1'b1;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    tick();
    chk("rst_rd_rdy_idle", bus.rd_rdy, 1);
    do_read(32'h300, 3'b100, -1, '0, '0, '0, 1'b0);
    do_read(32'h500, 3'b000, -1, '0, '0, '0, 1'b0);

    for (int it = 0; it < 80; it++) begin
      a = $urandom;
      t = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        do_write($urandom, 3'($urandom_range(3, 4)), rnd128());
      end
      inj = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, RL + ((t == 3'b100) ? 4 : 1));
      wa  = ($urandom_range(0, 1) == 1) ? (a ^ (32'($urandom_range(0, 3)) << 2)) : $urandom;
      wt  = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b001;
      do_read(a, t, inj, wa, wt, rnd128(), 1'($urandom_range(0, 1)));
      repeat (WL) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
